// File: rtl/lif_pkg.sv
// Shared definitions for the sparse LIF neuron array.
//   lif_fsm_e  : array controller states (idle / leak sweep)
//   lif_mode_e : shared datapath operation (integrate a beat / leak one neuron)
//   RefractW   : width of each per-neuron refractory counter
//   idx_width(): neuron-index width, never narrower than one bit
package lif_pkg;

  localparam int unsigned RefractW = 4;

  typedef enum logic {
    StIdle,
    StSweep
  } lif_fsm_e;

  typedef enum logic {
    ModeIntegrate,
    ModeLeak
  } lif_mode_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational update for one leaky integrate-and-fire neuron.
// Ports:
//   mode         : ModeIntegrate (apply current) or ModeLeak (one leak step)
//   state        : current membrane state
//   current      : input current (integrate only)
//   thr          : firing threshold (integrate only)
//   refract      : current refractory count
//   next_state   : state to write back
//   next_refract : refractory count to write back
//   spike        : neuron fires this update
//   skip         : nothing to do; caller suppresses the write and counts it
module lif_update
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned LEAK_SHIFT    = 1,
  parameter int unsigned REFRACT_TICKS = 2
) (
  input  lif_mode_e           mode,
  input  logic [WIDTH-1:0]    state,
  input  logic [WIDTH-1:0]    current,
  input  logic [WIDTH-1:0]    thr,
  input  logic [RefractW-1:0] refract,
  output logic [WIDTH-1:0]    next_state,
  output logic [RefractW-1:0] next_refract,
  output logic                spike,
  output logic                skip
);

  logic [WIDTH:0]   sum_wide;
  logic [WIDTH-1:0] sum_sat;
  logic [WIDTH-1:0] leak_raw;
  logic [WIDTH-1:0] leak_amt;

  assign sum_wide = {1'b0, state} + {1'b0, current};
  assign sum_sat  = sum_wide[WIDTH] ? '1 : sum_wide[WIDTH-1:0];

  // A nonzero state always decays by at least one so it eventually reaches zero.
  assign leak_raw = state >> LEAK_SHIFT;
  assign leak_amt = (leak_raw == '0) ? WIDTH'(1) : leak_raw;

  always_comb begin
    next_state   = state;
    next_refract = refract;
    spike        = 1'b0;
    skip         = 1'b0;
    unique case (mode)
      ModeIntegrate: begin
        if (refract != '0) begin
          // Refractory: input is dropped.
        end else if (current == '0) begin
          skip = 1'b1;
        end else if (sum_sat >= thr) begin
          spike        = 1'b1;
          next_state   = '0;
          next_refract = RefractW'(REFRACT_TICKS);
        end else begin
          next_state = sum_sat;
        end
      end
      ModeLeak: begin
        if (refract != '0) begin
          next_refract = refract - RefractW'(1);
        end else if (state != '0) begin
          next_state = state - leak_amt;
        end else begin
          skip = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sparse_lif_array.sv
// Time-multiplexed array of N_NEURONS leaky integrate-and-fire neurons sharing one
// lif_update datapath. In idle, one current beat per cycle is integrated; a tick
// starts an N_NEURONS-cycle leak sweep over every neuron.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready       : current beat handshake (ready only while idle)
//   in_idx, in_current, thr : target neuron, current, firing threshold
//   tick                    : starts a leak sweep when idle
//   spike_valid, spike_idx  : one-cycle spike pulse and neuron index
//   state_out               : post-update state of the last written/examined neuron
//   busy, sweep_done        : sweep in progress, last sweep cycle
//   skip_count              : saturating count of skipped updates
module sparse_lif_array
  import lif_pkg::*;
#(
  parameter int unsigned N_NEURONS     = 4,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned LEAK_SHIFT    = 1,
  parameter int unsigned REFRACT_TICKS = 2,
  parameter int unsigned SKIP_W        = 16,
  parameter int unsigned IDX_W         = idx_width(N_NEURONS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [WIDTH-1:0]  in_current,
  input  logic [WIDTH-1:0]  thr,
  input  logic              tick,
  output logic              spike_valid,
  output logic [IDX_W-1:0]  spike_idx,
  output logic [WIDTH-1:0]  state_out,
  output logic              busy,
  output logic              sweep_done,
  output logic [SKIP_W-1:0] skip_count
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_NEURONS - 1);

  lif_fsm_e         fsm_q, fsm_d;
  logic [IDX_W-1:0] k_q, k_d;

  logic [WIDTH-1:0]    state_q   [N_NEURONS];
  logic [RefractW-1:0] refract_q [N_NEURONS];

  logic              spike_valid_q;
  logic [IDX_W-1:0]  spike_idx_q;
  logic [WIDTH-1:0]  state_out_q;
  logic [SKIP_W-1:0] skip_count_q;

  logic                sweeping;
  logic                accept;
  logic                idx_ok;
  logic                do_upd;
  logic                write_en;
  logic [IDX_W-1:0]    sel_idx;
  lif_mode_e           upd_mode;
  logic [WIDTH-1:0]    upd_next_state;
  logic [RefractW-1:0] upd_next_refract;
  logic                upd_spike;
  logic                upd_skip;

  assign sweeping = (fsm_q == StSweep);
  // Gated by rst_n so every output reads zero while reset is held.
  assign in_ready = rst_n & (fsm_q == StIdle);
  assign accept   = in_valid & in_ready;
  assign idx_ok   = (in_idx <= LastIdx);

  // Out-of-range beats read neuron 0 harmlessly; do_upd keeps them from acting.
  assign sel_idx  = sweeping ? k_q : (idx_ok ? in_idx : '0);
  assign upd_mode = sweeping ? ModeLeak : ModeIntegrate;
  assign do_upd   = sweeping | (accept & idx_ok);
  assign write_en = do_upd & ~upd_skip;

  lif_update #(
    .WIDTH        (WIDTH),
    .LEAK_SHIFT   (LEAK_SHIFT),
    .REFRACT_TICKS(REFRACT_TICKS)
  ) u_update (
    .mode        (upd_mode),
    .state       (state_q[sel_idx]),
    .current     (in_current),
    .thr         (thr),
    .refract     (refract_q[sel_idx]),
    .next_state  (upd_next_state),
    .next_refract(upd_next_refract),
    .spike       (upd_spike),
    .skip        (upd_skip)
  );

  always_comb begin
    fsm_d = fsm_q;
    k_d   = k_q;
    unique case (fsm_q)
      StIdle: begin
        if (tick) begin
          fsm_d = StSweep;
          k_d   = '0;
        end
      end
      StSweep: begin
        if (k_q == LastIdx) begin
          fsm_d = StIdle;
          k_d   = '0;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= StIdle;
      k_q   <= '0;
    end else begin
      fsm_q <= fsm_d;
      k_q   <= k_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        state_q[i]   <= '0;
        refract_q[i] <= '0;
      end
    end else if (write_en) begin
      state_q[sel_idx]   <= upd_next_state;
      refract_q[sel_idx] <= upd_next_refract;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      state_out_q   <= '0;
      skip_count_q  <= '0;
    end else begin
      spike_valid_q <= do_upd & upd_spike;
      if (do_upd & upd_spike) begin
        spike_idx_q <= sel_idx;
      end
      if (do_upd) begin
        state_out_q <= upd_next_state;
      end
      if (do_upd & upd_skip & (skip_count_q != '1)) begin
        skip_count_q <= skip_count_q + SKIP_W'(1);
      end
    end
  end

  assign spike_valid = spike_valid_q;
  assign spike_idx   = spike_idx_q;
  assign state_out   = state_out_q;
  assign skip_count  = skip_count_q;
  assign busy        = sweeping;
  assign sweep_done  = sweeping & (k_q == LastIdx);

endmodule

// File: tb/tb_sparse_lif_array.sv
module tb_sparse_lif_array;

  localparam int N = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_idx;
  logic [7:0]  in_current;
  logic [7:0]  thr;
  logic        tick;
  logic        spike_valid;
  logic [1:0]  spike_idx;
  logic [7:0]  state_out;
  logic        busy;
  logic        sweep_done;
  logic [15:0] skip_count;

  // Three-neuron instance for the out-of-range index case.
  logic        in_valid3;
  logic        in_ready3;
  logic [1:0]  in_idx3;
  logic [7:0]  in_current3;
  logic        spike_valid3;
  logic [1:0]  spike_idx3;
  logic [7:0]  state_out3;
  logic        busy3;
  logic        sweep_done3;
  logic [15:0] skip_count3;
  logic        tick3;

  sparse_lif_array dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_current (in_current),
    .thr        (thr),
    .tick       (tick),
    .spike_valid(spike_valid),
    .spike_idx  (spike_idx),
    .state_out  (state_out),
    .busy       (busy),
    .sweep_done (sweep_done),
    .skip_count (skip_count)
  );

  sparse_lif_array #(.N_NEURONS(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid3),
    .in_ready   (in_ready3),
    .in_idx     (in_idx3),
    .in_current (in_current3),
    .thr        (thr),
    .tick       (tick3),
    .spike_valid(spike_valid3),
    .spike_idx  (spike_idx3),
    .state_out  (state_out3),
    .busy       (busy3),
    .sweep_done (sweep_done3),
    .skip_count (skip_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit spike;
    int idx;
    int st;
    int skip;
  } exp_t;

  exp_t sb[$];

  int m_state[N];
  int m_ref[N];
  int m_skip;
  int m_thr;
  int last_out;
  int n_checks;
  int n_errors;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0;
      m_ref[i]   = 0;
    end
    m_skip   = 0;
    last_out = 0;
    sb.delete();
  endfunction

  function automatic void bump_skip();
    if (m_skip < 65535) m_skip++;
  endfunction

  // Reference behaviour of one accepted beat; pushes the expected registered result.
  function automatic void model_beat(input int i, input int cur);
    exp_t e;
    int   sum;
    e.spike = 0;
    e.idx   = 0;
    e.st    = last_out;
    if (i < N) begin
      if (m_ref[i] != 0) begin
        e.st = m_state[i];
      end else if (cur == 0) begin
        bump_skip();
        e.st = m_state[i];
      end else begin
        sum = m_state[i] + cur;
        if (sum > 255) sum = 255;
        if (sum >= m_thr) begin
          e.spike    = 1;
          e.idx      = i;
          m_state[i] = 0;
          m_ref[i]   = 2;
        end else begin
          m_state[i] = sum;
        end
        e.st = m_state[i];
      end
    end
    e.skip   = m_skip;
    last_out = e.st;
    sb.push_back(e);
  endfunction

  function automatic void model_sweep();
    exp_t e;
    int   d;
    for (int k = 0; k < N; k++) begin
      if (m_ref[k] != 0) begin
        m_ref[k]--;
      end else if (m_state[k] != 0) begin
        d = m_state[k] >> 1;
        if (d == 0) d = 1;
        m_state[k] -= d;
      end else begin
        bump_skip();
      end
      e.spike  = 0;
      e.idx    = 0;
      e.st     = m_state[k];
      e.skip   = m_skip;
      last_out = e.st;
      sb.push_back(e);
    end
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got state_out %0d expected an entry", tag, state_out);
    end else begin
      e = sb.pop_front();
      check({tag, "_spike"}, int'(spike_valid), int'(e.spike));
      if (e.spike) check({tag, "_spike_idx"}, int'(spike_idx), e.idx);
      check({tag, "_state_out"}, int'(state_out), e.st);
      check({tag, "_skip"}, int'(skip_count), e.skip);
    end
  endtask

  task automatic beat(input int i, input int cur);
    in_valid   = 1'b1;
    in_idx     = 2'(i);
    in_current = 8'(cur);
    model_beat(i, cur);
    step();
    in_valid = 1'b0;
    compare_out("beat");
  endtask

  task automatic idle_check();
    step();
    check("spike_one_cycle", int'(spike_valid), 0);
  endtask

  // Tick (optionally with a simultaneous beat), then follow the whole sweep.
  task automatic run_tick(input bit with_beat, input int i, input int cur, input bit tick_mid);
    int done_cnt;
    done_cnt = 0;
    tick = 1'b1;
    if (with_beat) begin
      in_valid   = 1'b1;
      in_idx     = 2'(i);
      in_current = 8'(cur);
      model_beat(i, cur);
    end
    step();
    tick     = 1'b0;
    in_valid = 1'b0;
    if (with_beat) compare_out("tick_beat");
    model_sweep();
    for (int k = 0; k < N; k++) begin
      check("sweep_busy", int'(busy), 1);
      check("sweep_ready", int'(in_ready), 0);
      check("sweep_done_k", int'(sweep_done), (k == N - 1) ? 1 : 0);
      if (sweep_done) done_cnt++;
      if (k > 0) compare_out("sweep");
      if (tick_mid && k == 1) tick = 1'b1;
      step();
      tick = 1'b0;
    end
    compare_out("sweep_last");
    check("busy_after_sweep", int'(busy), 0);
    for (int c = 0; c < 3; c++) begin
      if (sweep_done) done_cnt++;
      check("idle_after_sweep", int'(busy), 0);
      step();
    end
    check("sweep_done_count", done_cnt, 1);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_idx      = '0;
    in_current  = '0;
    thr         = 8'd100;
    m_thr       = 100;
    tick        = 1'b0;
    in_valid3   = 1'b0;
    in_idx3     = '0;
    in_current3 = '0;
    tick3       = 1'b0;
    model_reset();

    // Power-on reset.
    step();
    step();
    check("rst_ready", int'(in_ready), 0);
    check("rst_state_out", int'(state_out), 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", int'(in_ready), 1);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_skip", int'(skip_count), 0);

    // Reset in the middle of a sweep.
    beat(0, 80);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    check("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(in_ready), 0);
    check("mid_rst_done", int'(sweep_done), 0);
    check("mid_rst_spike", int'(spike_valid), 0);
    check("mid_rst_state_out", int'(state_out), 0);
    check("mid_rst_skip", int'(skip_count), 0);
    step();
    rst_n = 1'b1;
    #1;
    model_reset();
    check("rel_ready", int'(in_ready), 1);
    check("rel_busy", int'(busy), 0);
    check("rel_skip", int'(skip_count), 0);
    beat(0, 0);  // neuron 0 must read back cleared

    // Integrate and fire.
    beat(2, 60);
    beat(2, 50);
    idle_check();

    // Refractory: dropped, two sweeps, then fires again.
    beat(2, 120);
    run_tick(1'b0, 0, 0, 1'b0);
    run_tick(1'b0, 0, 0, 1'b0);
    beat(2, 120);
    idle_check();

    // Leak and sparsity.
    beat(0, 80);
    beat(1, 1);
    run_tick(1'b0, 0, 0, 1'b0);
    beat(3, 0);
    beat(0, 0);

    // Saturation at threshold 255.
    thr   = 8'd255;
    m_thr = 255;
    beat(1, 200);
    beat(1, 100);
    idle_check();

    // Out-of-range index on a three-neuron array.
    in_valid3   = 1'b1;
    in_idx3     = 2'd2;
    in_current3 = 8'd50;
    step();
    check("n3_valid_idx_state", int'(state_out3), 50);
    in_idx3 = 2'd3;
    step();
    in_valid3 = 1'b0;
    check("n3_oor_spike", int'(spike_valid3), 0);
    check("n3_oor_state_out", int'(state_out3), 50);
    check("n3_oor_skip", int'(skip_count3), 0);

    // Tick and beat together; second tick during the sweep is ignored.
    thr   = 8'd100;
    m_thr = 100;
    run_tick(1'b1, 3, 30, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
